// File: rtl/trivium_pkg.sv
// trivium_pkg: shared widths, loader state type and counter sizing for the Trivium core.
package trivium_pkg;

    localparam int KEY_W = 80;
    localparam int IV_W  = 80;

    typedef enum logic [1:0] {LOAD_KEY, LOAD_IV, ARM, RUN} kiv_state_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: synchronises an asynchronous pin and emits a registered one-cycle pulse per rising edge.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic hist_q, rise_q, rise_d;

    assign sync_d = {sync_q[STAGES-2:0], async_in};
    assign rise_d = sync_q[STAGES-1] & ~hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= sync_q[STAGES-1];
            rise_q <= rise_d;
        end
    end

    assign rise_pulse = rise_q;

endmodule

// File: rtl/trivium_kiv_loader.sv
// trivium_kiv_loader: collects key then IV bytes from a strobed byte pin and
// hands them to the cipher with a load pulse followed by a steady enable.
module trivium_kiv_loader
    import trivium_pkg::*;
#(
    parameter int KEY_BYTES   = KEY_W / 8,
    parameter int IV_BYTES    = IV_W / 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data_in,
    input  logic                   strobe_in,
    input  logic                   cmd_restart,
    output logic [8*KEY_BYTES-1:0] key,
    output logic [8*IV_BYTES-1:0]  iv,
    output logic                   cipher_load,
    output logic                   cipher_en,
    output logic                   busy,
    output logic                   byte_ack
);

    localparam int CNT_W = cnt_width(KEY_BYTES, IV_BYTES);
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
    localparam logic [CNT_W-1:0] IV_LAST  = CNT_W'(IV_BYTES - 1);

    kiv_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [8*IV_BYTES-1:0]  iv_q, iv_d;
    logic                   ack_q, ack_d;
    logic                   take;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_strobe (
        .clk       (clk),
        .rst       (rst),
        .async_in  (strobe_in),
        .rise_pulse(take)
    );

    // Restart wins over a byte arriving in the same cycle; that byte is lost.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        iv_d    = iv_q;
        ack_d   = 1'b0;
        if (cmd_restart) begin
            state_d = LOAD_KEY;
            cnt_d   = '0;
            key_d   = '0;
            iv_d    = '0;
        end else begin
            case (state_q)
                LOAD_KEY: if (take) begin
                    key_d[{cnt_q, 3'b000} +: 8] = data_in;
                    ack_d   = 1'b1;
                    cnt_d   = (cnt_q == KEY_LAST) ? '0 : cnt_q + 1'b1;
                    state_d = (cnt_q == KEY_LAST) ? LOAD_IV : LOAD_KEY;
                end
                LOAD_IV: if (take) begin
                    iv_d[{cnt_q, 3'b000} +: 8] = data_in;
                    ack_d   = 1'b1;
                    cnt_d   = (cnt_q == IV_LAST) ? '0 : cnt_q + 1'b1;
                    state_d = (cnt_q == IV_LAST) ? ARM : LOAD_IV;
                end
                ARM:     state_d = RUN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_KEY;
            cnt_q   <= '0;
            key_q   <= '0;
            iv_q    <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            iv_q    <= iv_d;
            ack_q   <= ack_d;
        end
    end

    assign key         = key_q;
    assign iv          = iv_q;
    assign byte_ack    = ack_q;
    assign busy        = (state_q == LOAD_KEY) || (state_q == LOAD_IV);
    assign cipher_en   = (state_q == RUN);
    assign cipher_load = (state_q == ARM) && !cmd_restart;

endmodule

// File: tb/tb_trivium_kiv_loader.sv
// tb_trivium_kiv_loader: randomized byte loading checked every cycle against a
// byte-count reference model, plus literal checks from hand-worked cases.
module tb_trivium_kiv_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        strobe_in = 1'b0;
    logic        cmd_restart = 1'b0;
    logic [79:0] key, iv;
    logic        cipher_load, cipher_en, busy, byte_ack;

    trivium_kiv_loader dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .strobe_in  (strobe_in),
        .cmd_restart(cmd_restart),
        .key        (key),
        .iv         (iv),
        .cipher_load(cipher_load),
        .cipher_en  (cipher_en),
        .busy       (busy),
        .byte_ack   (byte_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rise_q[$];
    int last_rise = 0;
    int ack_cnt = 0;
    int load_cyc = -1;

    // Model: bytes accepted so far (0..19 loading, 20 = load pulse, 21 = running).
    logic [79:0] m_key = '0, m_iv = '0;
    int          m_total = 0;
    bit          m_ack = 1'b0;
    bit          m_tk;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // A pin rise in cycle c is accepted at the end of cycle c+3 and visible from c+4.
    task automatic model_step();
        if (rst) begin
            m_key = '0; m_iv = '0; m_total = 0; m_ack = 1'b0;
            rise_q.delete();
        end else begin
            m_tk = 1'b0;
            while (rise_q.size() > 0 && rise_q[0] + 3 < cyc) void'(rise_q.pop_front());
            if (rise_q.size() > 0 && rise_q[0] + 3 == cyc) begin
                m_tk = 1'b1;
                void'(rise_q.pop_front());
            end
            m_ack = 1'b0;
            if (cmd_restart) begin
                m_key = '0; m_iv = '0; m_total = 0;
            end else if (m_tk && m_total < 10) begin
                m_key[8*m_total +: 8] = data_in;
                m_total++;
                m_ack = 1'b1;
            end else if (m_tk && m_total < 20) begin
                m_iv[8*(m_total-10) +: 8] = data_in;
                m_total++;
                m_ack = 1'b1;
            end else if (m_total == 20) begin
                m_total = 21;
            end
            cyc++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("busy", 80'(busy), 80'(m_total < 20));
            chk("cipher_en", 80'(cipher_en), 80'(m_total == 21));
            chk("cipher_load", 80'(cipher_load), 80'(m_total == 20 && !cmd_restart));
            chk("byte_ack", 80'(byte_ack), 80'(m_ack));
            chk("key", key, m_key);
            chk("iv", iv, m_iv);
            if (byte_ack) ack_cnt++;
            if (cipher_load) load_cyc = cyc;
        end
    end

    task automatic send(input logic [7:0] d, input int hold, input bit rot);
        @(posedge clk); #1;
        data_in = d;
        strobe_in = 1'b1;
        rise_q.push_back(cyc);
        last_rise = cyc;
        for (int i = 1; i <= ((hold > 4) ? hold : 4); i++) begin
            @(posedge clk); #1;
            if (i == hold) strobe_in = 1'b0;
            cmd_restart = rot && (i == 3);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic restart_pulse();
        @(posedge clk); #1 cmd_restart = 1'b1;
        @(posedge clk); #1 cmd_restart = 1'b0;
    endtask

    task automatic load_random();
        restart_pulse();
        for (int i = 0; i < 20; i++) send(8'($urandom), 3, 1'b0);
        repeat (6) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 80'(busy), 80'd1);
        chk("reset_en", 80'(cipher_en), 80'd0);
        chk("reset_key", key, 80'd0);
        chk("reset_iv", iv, 80'd0);
        repeat (10) begin @(posedge clk); #1 data_in = 8'($urandom); end
        repeat (4) @(posedge clk);
        chk("idle_key", key, 80'd0);

        send(8'h55, 30, 1'b0);
        repeat (4) @(posedge clk);
        chk("held_key_lsb", 80'(key[7:0]), 80'h55);
        chk("held_ack_cnt", 80'(ack_cnt), 80'd1);
        restart_pulse();

        ack_cnt = 0;
        for (int i = 0; i < 10; i++) send(8'(8'h01 + i), 3, 1'b0);
        for (int i = 0; i < 10; i++) send(8'(8'hF0 + i), 3, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("full_key", key, 80'h0A090807060504030201);
        chk("full_iv", iv, 80'hF9F8F7F6F5F4F3F2F1F0);
        chk("full_ack_cnt", 80'(ack_cnt), 80'd20);
        chk("load_latency", 80'(load_cyc - last_rise), 80'd4);
        chk("full_en", 80'(cipher_en), 80'd1);
        chk("full_busy", 80'(busy), 80'd0);

        for (int i = 0; i < 5; i++) send(8'hFF, 3, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("run_key", key, 80'h0A090807060504030201);
        chk("run_iv", iv, 80'hF9F8F7F6F5F4F3F2F1F0);
        chk("run_ack_cnt", 80'(ack_cnt), 80'd20);
        chk("run_en", 80'(cipher_en), 80'd1);

        restart_pulse();
        for (int i = 0; i < 13; i++) send(8'($urandom_range(1, 255)), 3, 1'b0);
        send(8'hA5, 3, 1'b1);
        @(negedge clk);
        chk("restart_key", key, 80'd0);
        chk("restart_iv", iv, 80'd0);
        chk("restart_busy", 80'(busy), 80'd1);
        for (int i = 0; i < 20; i++) send(8'($urandom), 3, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("reload_en", 80'(cipher_en), 80'd1);

        for (int i = 0; i < 60; i++)
            send(8'($urandom), int'($urandom_range(1, 8)), $urandom_range(0, 9) == 0);

        load_random();
        @(negedge clk);
        chk("pre_reset_en", 80'(cipher_en), 80'd1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("async_en", 80'(cipher_en), 80'd0);
        chk("async_key", key, 80'd0);
        chk("async_iv", iv, 80'd0);
        chk("async_busy", 80'(busy), 80'd1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
